// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM encoding, default sizing and clog2 helper for the UART TX arbiter.
package uart_pkg;
   localparam int NREQ_DEF = 4;
   localparam int DW_DEF   = 4;
   localparam int TMO_DEF  = 15;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      LAUNCH    = 2'd1,
      WAIT_DONE = 2'd2,
      RECOVER   = 2'd3
   } state_t;

   function automatic int clog2(input int n);
      int r = 1;
      for (int i = 1; i < 32; i++) r = ((1 << i) < n) ? i + 1 : r;
      return r;
   endfunction
endpackage

// File: rtl/uart_rr_pick.sv
// uart_rr_pick: combinational winner selection, first valid requester at or after ptr.
module uart_rr_pick #(
   parameter int N  = 4,
   parameter int IW = 2
) (
   input  logic [N-1:0]  valid,
   input  logic [IW-1:0] ptr,
   output logic [IW-1:0] win
);
   logic [N-1:0]  rot;
   logic [IW-1:0] off;
   logic [IW:0]   sum;

   always_comb begin
      rot = N'({valid, valid} >> ptr);
      off = '0;
      for (int k = N - 1; k >= 0; k--) off = rot[k] ? IW'(k) : off;
      sum = {1'b0, ptr} + {1'b0, off};
      win = (sum >= (IW+1)'(N)) ? IW'(sum - (IW+1)'(N)) : sum[IW-1:0];
   end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART transmitter among NREQ requesters with a launch timeout.
// Define UART_ARB_ROUND_ROBIN_EN for round-robin arbitration; default is fixed priority.
module uart_tx_arbiter import uart_pkg::*; #(
   parameter  int NREQ = NREQ_DEF,
   parameter  int DW   = DW_DEF,
   parameter  int TMO  = TMO_DEF,
   localparam int IW   = clog2(NREQ)
) (
   input  logic              internalclk,
   input  logic              RESETN,
   input  logic [NREQ-1:0]   req_valid,
   input  logic [NREQ*DW-1:0] req_data,
   output logic [NREQ-1:0]   req_ready,
   output logic [NREQ-1:0]   req_done,
   output logic              tx_start,
   output logic [DW-1:0]     tx_din,
   input  logic              tx_busy,
   output logic [IW-1:0]     grant_id,
   output logic              active,
   output logic              err
);
   state_t        state;
   logic [7:0]    cnt;
   logic [IW-1:0] ptr;
   logic [IW-1:0] win;
   logic [DW-1:0] data_a [NREQ];

   for (genvar i = 0; i < NREQ; i++) begin : g_data
      assign data_a[i] = req_data[i*DW +: DW];
   end

   uart_rr_pick #(.N(NREQ), .IW(IW)) u_pick (
      .valid (req_valid),
      .ptr   (ptr),
      .win   (win)
   );

`ifdef UART_ARB_ROUND_ROBIN_EN
   logic [IW-1:0] nxt;
   assign nxt = (grant_id == IW'(NREQ - 1)) ? '0 : grant_id + 1'b1;
   // A timed-out requester is skipped when RECOVER hands back to IDLE.
   always_ff @(posedge internalclk or posedge RESETN)
      if (RESETN) ptr <= '0;
      else if ((state == WAIT_DONE && !tx_busy) || state == RECOVER) ptr <= nxt;
`else
   assign ptr = '0;
`endif

   assign active = (state != IDLE);

   always_ff @(posedge internalclk or posedge RESETN)
      if (RESETN) begin
         state     <= IDLE;
         tx_start  <= 1'b0;
         tx_din    <= '0;
         req_ready <= '0;
         req_done  <= '0;
         grant_id  <= '0;
         err       <= 1'b0;
         cnt       <= '0;
      end else begin
         req_ready <= '0;
         req_done  <= '0;
         err       <= 1'b0;
         case (state)
            IDLE: if (|req_valid && !tx_busy) begin
               state     <= LAUNCH;
               tx_start  <= 1'b1;
               tx_din    <= data_a[win];
               req_ready <= NREQ'(1) << win;
               grant_id  <= win;
               cnt       <= '0;
            end
            LAUNCH: if (tx_busy) begin
               state    <= WAIT_DONE;
               tx_start <= 1'b0;
            end else begin
               cnt <= (cnt == 8'(TMO)) ? cnt : cnt + 8'd1;
               if (cnt + 8'd1 >= 8'(TMO)) begin
                  state    <= RECOVER;
                  tx_start <= 1'b0;
                  err      <= 1'b1;
               end
            end
            WAIT_DONE: if (!tx_busy) begin
               state    <= IDLE;
               req_done <= NREQ'(1) << grant_id;
            end
            default: state <= IDLE;
         endcase
      end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed and randomized checks against a frame-level reference model.
module tb_uart_tx_arbiter;
   localparam int N   = 4;
   localparam int DW  = 4;
   localparam int TMO = 15;
   localparam int IW  = 2;

   logic            clk = 1'b0;
   logic            RESETN = 1'b0;
   logic            tx_busy = 1'b0;
   logic [N-1:0]    req_valid = '0;
   logic [N*DW-1:0] req_data = '0;
   logic [N-1:0]    req_ready, req_done;
   logic            tx_start, active, err;
   logic [DW-1:0]   tx_din;
   logic [IW-1:0]   grant_id;

   int n_chk = 0;
   int n_fail = 0;
   bit chk_on = 0;

   uart_tx_arbiter #(.NREQ(N), .DW(DW), .TMO(TMO)) dut (
      .internalclk (clk),
      .RESETN      (RESETN),
      .req_valid   (req_valid),
      .req_data    (req_data),
      .req_ready   (req_ready),
      .req_done    (req_done),
      .tx_start    (tx_start),
      .tx_din      (tx_din),
      .tx_busy     (tx_busy),
      .grant_id    (grant_id),
      .active      (active),
      .err         (err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference model: a frame is either waiting for the transmitter to go busy,
   // transmitting, or cooling down one cycle after a timeout.
   bit m_fly, m_lau, m_cool;
   int m_age, m_g, m_ptr, m_din;
   int e_ready, e_done, e_err;
   logic [N*DW-1:0] sh;

   function automatic int pick(input logic [N-1:0] v, input int p);
      for (int k = 0; k < N; k++) if (v[(p + k) % N]) return (p + k) % N;
      return 0;
   endfunction

   function automatic int next_ptr(input int g);
`ifdef UART_ARB_ROUND_ROBIN_EN
      return (g + 1) % N;
`else
      return 0 * g;
`endif
   endfunction

   always @(posedge clk) begin
      e_ready = 0;
      e_done  = 0;
      e_err   = 0;
      if (RESETN) begin
         m_fly = 0; m_lau = 0; m_cool = 0; m_age = 0; m_g = 0; m_ptr = 0; m_din = 0;
      end else if (m_cool) begin
         m_cool = 0;
      end else if (!m_fly) begin
         if (req_valid != 0 && !tx_busy) begin
            m_g = pick(req_valid, m_ptr);
            m_fly = 1; m_lau = 0; m_age = 0;
            e_ready = 1 << m_g;
            sh = req_data >> (m_g * DW);
            m_din = int'(sh[DW-1:0]);
         end
      end else if (!m_lau) begin
         if (tx_busy) m_lau = 1;
         else begin
            m_age++;
            if (m_age == TMO) begin
               m_fly = 0; m_cool = 1; e_err = 1; m_ptr = next_ptr(m_g);
            end
         end
      end else if (!tx_busy) begin
         m_fly = 0; e_done = 1 << m_g; m_ptr = next_ptr(m_g);
      end
   end

   always @(negedge clk) if (chk_on) begin
      chk("req_ready", int'(req_ready), RESETN ? 0 : e_ready);
      chk("req_done",  int'(req_done),  RESETN ? 0 : e_done);
      chk("err",       int'(err),       RESETN ? 0 : e_err);
      chk("tx_start",  int'(tx_start),  RESETN ? 0 : int'(m_fly && !m_lau));
      chk("tx_din",    int'(tx_din),    RESETN ? 0 : m_din);
      chk("grant_id",  int'(grant_id),  RESETN ? 0 : m_g);
      chk("active",    int'(active),    RESETN ? 0 : int'(m_fly || m_cool));
   end

   task automatic wait_ready();
      for (int k = 0; k < 30 && req_ready == 0; k++) step();
      chk("ready_seen", int'(req_ready != 0), 1);
   endtask

   task automatic finish_frame();
      tx_busy = 1'b1;
      step();
      step();
      tx_busy = 1'b0;
      step();
   endtask

   task automatic rst_pulse();
      RESETN = 1'b1;
      step();
      RESETN = 1'b0;
      tx_busy = 1'b0;
      req_valid = '0;
   endtask

   int n, nf, lw, bcnt, ge;

   initial begin
      #2 RESETN = 1'b1;
      chk_on = 1;
      repeat (3) step();
      chk("rst_ready", int'(req_ready), 0);
      chk("rst_start", int'(tx_start), 0);
      chk("rst_din", int'(tx_din), 0);
      chk("rst_active", int'(active), 0);
      chk("rst_grant", int'(grant_id), 0);

      // single request on requester 2
      req_data = 16'h0A00;
      req_valid = 4'b0100;
      RESETN = 1'b0;
      step();
      chk("d1_ready", int'(req_ready), 4);
      chk("d1_din", int'(tx_din), 10);
      chk("d1_start", int'(tx_start), 1);
      chk("d1_grant", int'(grant_id), 2);
      req_valid = '0;
      step();
      chk("d1_ready_pulse", int'(req_ready), 0);
      chk("d1_start_hold", int'(tx_start), 1);
      tx_busy = 1'b1;
      step();
      chk("d1_start_drop", int'(tx_start), 0);
      step();
      tx_busy = 1'b0;
      step();
      chk("d1_done", int'(req_done), 4);
      step();
      chk("d1_done_pulse", int'(req_done), 0);
      chk("d1_idle", int'(active), 0);

      // held requests over several frames
      rst_pulse();
      req_data = 16'h4321;
`ifdef UART_ARB_ROUND_ROBIN_EN
      req_valid = 4'b1111;
      nf = 4;
`else
      req_valid = 4'b1010;
      nf = 2;
`endif
      for (int f = 0; f < nf; f++) begin
         wait_ready();
`ifdef UART_ARB_ROUND_ROBIN_EN
         ge = f;
`else
         ge = 1;
`endif
         chk("d2_grant", int'(grant_id), ge);
         chk("d2_din", int'(tx_din), ge + 1);
         finish_frame();
         chk("d2_done", int'(req_done), 1 << ge);
      end
      req_valid = '0;
      step();

      // launch timeout with transmitter never busy
      rst_pulse();
      req_data = 16'h00B7;
      req_valid = 4'b0001;
      wait_ready();
      req_valid = '0;
      n = 0;
      for (int k = 1; k <= 40 && n == 0; k++) begin
         step();
         if (err) n = k;
      end
      chk("d3_tmo_cycles", n, TMO);
      chk("d3_start_off", int'(tx_start), 0);
      req_valid = 4'b0011;
      wait_ready();
`ifdef UART_ARB_ROUND_ROBIN_EN
      chk("d3_skip", int'(grant_id), 1);
`else
      chk("d3_skip", int'(grant_id), 0);
`endif
      req_valid = '0;
      finish_frame();
      step();

      // reset during WAIT_DONE, then accept held off by a busy transmitter
      req_valid = 4'b0100;
      wait_ready();
      req_valid = '0;
      tx_busy = 1'b1;
      step();
      step();
      RESETN = 1'b1;
      #1;
      chk("d4_ready", int'(req_ready), 0);
      chk("d4_done", int'(req_done), 0);
      chk("d4_start", int'(tx_start), 0);
      chk("d4_din", int'(tx_din), 0);
      chk("d4_active", int'(active), 0);
      chk("d4_err", int'(err), 0);
      step();
      RESETN = 1'b0;
      req_valid = 4'b0001;
      for (int k = 0; k < 3; k++) begin
         step();
         chk("d4_busy_block", int'(req_ready), 0);
      end
      tx_busy = 1'b0;
      step();
      chk("d4_accept", int'(req_ready), 1);
      req_valid = '0;
      finish_frame();

      // randomized traffic
      lw = -1;
      bcnt = 0;
      for (int s = 0; s < 3000; s++) begin
         step();
         RESETN = ($urandom_range(399) == 0);
         for (int i = 0; i < N; i++) begin
            if (req_valid[i] && req_ready[i]) begin
               req_valid[i] = ($urandom_range(3) == 0);
               req_data[i*DW +: DW] = DW'($urandom);
            end else if (!req_valid[i] && $urandom_range(3) == 0) begin
               req_valid[i] = 1'b1;
               req_data[i*DW +: DW] = DW'($urandom);
            end
         end
         if (RESETN) lw = -1;
         if (tx_busy) begin
            if (bcnt <= 0) tx_busy = 1'b0;
            else bcnt--;
         end else if (tx_start) begin
            if (lw < 0) lw = ($urandom_range(7) == 0) ? 99 : int'($urandom_range(TMO));
            if (lw == 0) begin
               tx_busy = 1'b1;
               bcnt = int'($urandom_range(4));
               lw = -1;
            end else lw--;
         end else begin
            lw = -1;
            if (!active && $urandom_range(15) == 0) begin
               tx_busy = 1'b1;
               bcnt = int'($urandom_range(2));
            end
         end
      end
      RESETN = 1'b0;
      req_valid = '0;
      tx_busy = 1'b0;
      repeat (40) step();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
